pipearch_load_mc: RTL and testbench

- Generalised DRAM-to-on-chip loader. Streams a contiguous run of cache lines from host/DRAM memory into NUM_CHANNELS on-chip write channels (FIFO or BRAM writers).
- Two distribution modes:
  - Broadcast: every line goes to every enabled channel.
  - Round-robin: lines are spread across enabled channels in turn.
- A parametrised prefetch buffer provides credit-based request throttling. A cap on outstanding reads bounds in-flight traffic.
- Sits between the memory read port and the channel write adapters of a pipeline stage.

---
 rtl/pipearch_load_mc.sv | 219 +++++++++++++++++++++
 tb/tb_pipearch_load_mc.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipearch_load_mc.sv
// Streams a contiguous run of memory lines into NUM_CHANNELS write channels,
// either broadcast or round-robin, through a credit-gated prefetch FIFO.
module pipearch_load_mc #(
  parameter int NUM_CHANNELS        = 4,
  parameter int DATA_WIDTH          = 512,
  parameter int ADDR_WIDTH          = 42,
  parameter int LOG2_PREFETCH_DEPTH = 6,
  parameter int MAX_OUTSTANDING     = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    op_start,
  input  logic [ADDR_WIDTH-1:0]   cfg_addr,
  input  logic [31:0]             cfg_length,
  input  logic [NUM_CHANNELS-1:0] cfg_mask,
  input  logic                    cfg_mode,
  output logic                    op_busy,
  output logic                    op_done,
  output logic                    stray_rsp,
  output logic                    rd_req_valid,
  output logic [ADDR_WIDTH-1:0]   rd_req_addr,
  input  logic                    rd_req_almfull,
  input  logic                    rd_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   rd_rsp_data,
  output logic [NUM_CHANNELS-1:0] ch_we,
  output logic [DATA_WIDTH-1:0]   ch_wdata,
  input  logic [NUM_CHANNELS-1:0] ch_almostfull
);

  localparam int DEPTH = 2 ** LOG2_PREFETCH_DEPTH;
  localparam int PTR_W = LOG2_PREFETCH_DEPTH;
  localparam int CNT_W = LOG2_PREFETCH_DEPTH + 1;
  localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  localparam logic [1:0] RQ_IDLE = 2'd0;
  localparam logic [1:0] RQ_REQ  = 2'd1;
  localparam logic [1:0] RQ_DONE = 2'd2;
  localparam logic [1:0] RX_IDLE = 2'd0;
  localparam logic [1:0] RX_RUN  = 2'd1;
  localparam logic [1:0] RX_DONE = 2'd2;

  function automatic logic [CH_W-1:0] first_set(input logic [NUM_CHANNELS-1:0] m);
    first_set = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--)
      if (m[i]) first_set = CH_W'(i);
  endfunction

  // Smallest cyclic distance wins; distance NUM_CHANNELS returns cur itself.
  function automatic logic [CH_W-1:0] next_set(input logic [NUM_CHANNELS-1:0] m,
                                               input logic [CH_W-1:0] cur);
    logic [CH_W-1:0] sel;
    next_set = cur;
    for (int i = NUM_CHANNELS; i >= 1; i--) begin
      sel = CH_W'((int'(cur) + i) % NUM_CHANNELS);
      if (m[sel]) next_set = sel;
    end
  endfunction

  logic [1:0]              rq_state_q, rq_state_d;
  logic [1:0]              rx_state_q, rx_state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             len_q, len_d;
  logic [NUM_CHANNELS-1:0] mask_q, mask_d;
  logic                    mode_q, mode_d;
  logic [31:0]             req_cnt_q, req_cnt_d;
  logic [31:0]             rsp_cnt_q, rsp_cnt_d;
  logic [31:0]             wr_cnt_q, wr_cnt_d;
  logic [CH_W-1:0]         tgt_q, tgt_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        fifo_count_q, fifo_count_d;
  logic                    op_busy_q, op_busy_d;
  logic                    op_done_q, op_done_d;
  logic                    stray_q, stray_d;
  logic                    rd_req_valid_q, rd_req_valid_d;
  logic [ADDR_WIDTH-1:0]   rd_req_addr_q, rd_req_addr_d;
  logic [NUM_CHANNELS-1:0] ch_we_q, ch_we_d;
  logic [DATA_WIDTH-1:0]   ch_wdata_q, ch_wdata_d;
  logic [DATA_WIDTH-1:0]   fifo_mem_q [DEPTH];

  logic                    start_ok;
  logic                    cfg_empty;
  logic [31:0]             in_flight;
  logic                    issue;
  logic                    push;
  logic                    pop;
  logic                    tgt_ready;
  logic [NUM_CHANNELS-1:0] tgt_onehot;

  always_comb begin
    start_ok   = op_start && (rq_state_q == RQ_IDLE) && (rx_state_q == RX_IDLE);
    cfg_empty  = (cfg_length == 32'd0) || (cfg_mask == '0);
    in_flight  = req_cnt_q - rsp_cnt_q;
    issue      = (rq_state_q == RQ_REQ) && (req_cnt_q < len_q) && !rd_req_almfull &&
                 (in_flight < 32'(MAX_OUTSTANDING)) &&
                 ((32'(fifo_count_q) + in_flight) < 32'(DEPTH));
    push       = rd_rsp_valid && (rx_state_q == RX_RUN);
    tgt_onehot = NUM_CHANNELS'(1) << tgt_q;
    tgt_ready  = mode_q ? !ch_almostfull[tgt_q] : ((ch_almostfull & mask_q) == '0);
    pop        = (rx_state_q == RX_RUN) && (fifo_count_q != '0) && tgt_ready;
  end

  always_comb begin
    rq_state_d     = rq_state_q;
    rx_state_d     = rx_state_q;
    addr_d         = addr_q;
    len_d          = len_q;
    mask_d         = mask_q;
    mode_d         = mode_q;
    req_cnt_d      = issue ? req_cnt_q + 32'd1 : req_cnt_q;
    rsp_cnt_d      = push ? rsp_cnt_q + 32'd1 : rsp_cnt_q;
    wr_cnt_d       = pop ? wr_cnt_q + 32'd1 : wr_cnt_q;
    tgt_d          = (pop && mode_q) ? next_set(mask_q, tgt_q) : tgt_q;
    wr_ptr_d       = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d       = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    fifo_count_d   = fifo_count_q + CNT_W'(push) - CNT_W'(pop);
    op_busy_d      = op_busy_q;
    op_done_d      = (rx_state_q == RX_DONE);
    stray_d        = stray_q;
    rd_req_valid_d = issue;
    rd_req_addr_d  = issue ? addr_q + ADDR_WIDTH'(req_cnt_q) : rd_req_addr_q;
    ch_we_d        = pop ? (mode_q ? tgt_onehot : mask_q) : '0;
    ch_wdata_d     = pop ? fifo_mem_q[rd_ptr_q] : ch_wdata_q;

    if (start_ok) begin
      addr_d       = cfg_addr;
      len_d        = cfg_length;
      mask_d       = cfg_mask;
      mode_d       = cfg_mode;
      req_cnt_d    = '0;
      rsp_cnt_d    = '0;
      wr_cnt_d     = '0;
      tgt_d        = first_set(cfg_mask);
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      fifo_count_d = '0;
      op_busy_d    = 1'b1;
      stray_d      = 1'b0;
    end
    if (rx_state_q == RX_DONE) op_busy_d = 1'b0;
    // A response outside RUN has no transfer to belong to.
    if (rd_rsp_valid && (rx_state_q != RX_RUN)) stray_d = 1'b1;

    case (rq_state_q)
      RQ_IDLE: if (start_ok) rq_state_d = cfg_empty ? RQ_DONE : RQ_REQ;
      RQ_REQ:  if (issue && (req_cnt_q == len_q - 32'd1)) rq_state_d = RQ_DONE;
      RQ_DONE: rq_state_d = RQ_IDLE;
      default: rq_state_d = RQ_IDLE;
    endcase

    case (rx_state_q)
      RX_IDLE: if (start_ok) rx_state_d = cfg_empty ? RX_DONE : RX_RUN;
      RX_RUN:  if (pop && (wr_cnt_q == len_q - 32'd1)) rx_state_d = RX_DONE;
      RX_DONE: rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rq_state_q     <= RQ_IDLE;
      rx_state_q     <= RX_IDLE;
      addr_q         <= '0;
      len_q          <= '0;
      mask_q         <= '0;
      mode_q         <= 1'b0;
      req_cnt_q      <= '0;
      rsp_cnt_q      <= '0;
      wr_cnt_q       <= '0;
      tgt_q          <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      fifo_count_q   <= '0;
      op_busy_q      <= 1'b0;
      op_done_q      <= 1'b0;
      stray_q        <= 1'b0;
      rd_req_valid_q <= 1'b0;
      rd_req_addr_q  <= '0;
      ch_we_q        <= '0;
      ch_wdata_q     <= '0;
    end else begin
      rq_state_q     <= rq_state_d;
      rx_state_q     <= rx_state_d;
      addr_q         <= addr_d;
      len_q          <= len_d;
      mask_q         <= mask_d;
      mode_q         <= mode_d;
      req_cnt_q      <= req_cnt_d;
      rsp_cnt_q      <= rsp_cnt_d;
      wr_cnt_q       <= wr_cnt_d;
      tgt_q          <= tgt_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      fifo_count_q   <= fifo_count_d;
      op_busy_q      <= op_busy_d;
      op_done_q      <= op_done_d;
      stray_q        <= stray_d;
      rd_req_valid_q <= rd_req_valid_d;
      rd_req_addr_q  <= rd_req_addr_d;
      ch_we_q        <= ch_we_d;
      ch_wdata_q     <= ch_wdata_d;
    end
  end

  // Prefetch storage carries data only, so it is never reset.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= rd_rsp_data;
    if (push && !pop) assert (fifo_count_q != CNT_W'(DEPTH));
  end

  assign op_busy      = op_busy_q;
  assign op_done      = op_done_q;
  assign stray_rsp    = stray_q;
  assign rd_req_valid = rd_req_valid_q;
  assign rd_req_addr  = rd_req_addr_q;
  assign ch_we        = ch_we_q;
  assign ch_wdata     = ch_wdata_q;

endmodule

// File: tb/tb_pipearch_load_mc.sv
// Directed bench for pipearch_load_mc: memory responder model, write/request
// monitors and hand-computed expectations for each scenario.
module tb_pipearch_load_mc;

  localparam int NC  = 4;
  localparam int DW  = 32;
  localparam int AW  = 16;
  localparam int L2D = 3;
  localparam int MO  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          op_start = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [31:0]   cfg_length = '0;
  logic [NC-1:0] cfg_mask = '0;
  logic          cfg_mode = 1'b0;
  logic          op_busy, op_done, stray_rsp;
  logic          rd_req_valid;
  logic [AW-1:0] rd_req_addr;
  logic          rd_req_almfull = 1'b0;
  logic          rd_rsp_valid;
  logic [DW-1:0] rd_rsp_data;
  logic [NC-1:0] ch_we;
  logic [DW-1:0] ch_wdata;
  logic [NC-1:0] ch_almostfull = '0;

  pipearch_load_mc #(
    .NUM_CHANNELS(NC), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .LOG2_PREFETCH_DEPTH(L2D), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .reset(reset), .op_start(op_start), .cfg_addr(cfg_addr),
    .cfg_length(cfg_length), .cfg_mask(cfg_mask), .cfg_mode(cfg_mode),
    .op_busy(op_busy), .op_done(op_done), .stray_rsp(stray_rsp),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr),
    .rd_req_almfull(rd_req_almfull), .rd_rsp_valid(rd_rsp_valid),
    .rd_rsp_data(rd_rsp_data), .ch_we(ch_we), .ch_wdata(ch_wdata),
    .ch_almostfull(ch_almostfull)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] line_of(input logic [AW-1:0] a);
    return {16'hD00D, a};
  endfunction

  // Memory model: returns lines in request order after 'lat' cycles, holds while reset.
  int            lat = 3;
  logic [AW-1:0] mq_addr[$];
  int            mq_due[$];
  logic          m_valid = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic          inj_valid = 1'b0;
  assign rd_rsp_valid = m_valid | inj_valid;
  assign rd_rsp_data  = m_data;

  always @(negedge clk) begin
    m_valid <= 1'b0;
    if (rd_req_valid) begin
      mq_addr.push_back(rd_req_addr);
      mq_due.push_back(cyc + lat);
    end
    if (!reset && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      m_valid <= 1'b1;
      m_data  <= line_of(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
  end

  logic [AW-1:0] req_log[$];
  logic [NC-1:0] we_log[$];
  logic [DW-1:0] dat_log[$];
  int            wcyc_log[$];
  int            done_cnt = 0;
  int            done_cyc = 0;
  int            viol_cnt = 0;
  logic          almf_at_edge = 1'b0;

  always @(posedge clk) almf_at_edge <= rd_req_almfull;

  always @(negedge clk) begin
    if (rd_req_valid) begin
      req_log.push_back(rd_req_addr);
      if (almf_at_edge) viol_cnt <= viol_cnt + 1;
    end
    if (ch_we != '0) begin
      we_log.push_back(ch_we);
      dat_log.push_back(ch_wdata);
      wcyc_log.push_back(cyc);
    end
    if (op_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  int start_cyc = 0;

  task automatic start_op(input logic [AW-1:0] a, input int len, input logic [NC-1:0] m,
                          input logic md);
    cfg_addr   = a;
    cfg_length = len;
    cfg_mask   = m;
    cfg_mode   = md;
    op_start   = 1'b1;
    start_cyc  = cyc;
    tick();
    op_start   = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget);
    int n;
    n = 0;
    while (done_cnt == base && n < budget) begin
      tick();
      n++;
    end
    chk("done_seen", 64'(done_cnt != base), 64'd1);
  endtask

  function automatic logic [NC-1:0] we_at(input int idx);
    return (idx < we_log.size()) ? we_log[idx] : '1;
  endfunction

  function automatic logic [DW-1:0] dat_at(input int idx);
    return (idx < dat_log.size()) ? dat_log[idx] : '1;
  endfunction

  function automatic logic [AW-1:0] req_at(input int idx);
    return (idx < req_log.size()) ? req_log[idx] : '1;
  endfunction

  initial begin
    int rb, wb, db, vb, n;
    logic [NC-1:0] rr_exp [5];
    rr_exp = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0010};

    // Reset state
    tick(); tick();
    chk("rst_busy", op_busy, 0);
    chk("rst_done", op_done, 0);
    chk("rst_req", rd_req_valid, 0);
    chk("rst_we", ch_we, 0);
    chk("rst_wdata", ch_wdata, 0);
    reset = 1'b0;
    tick();

    // Broadcast, 3-cycle latency
    lat = 3;
    rb = req_log.size(); wb = we_log.size(); db = done_cnt;
    start_op(16'h1000, 8, 4'hF, 1'b0);
    chk("bc_busy_hi", op_busy, 1);
    wait_done(db, 200);
    repeat (3) tick();
    chk("bc_nreq", req_log.size() - rb, 8);
    for (int i = 0; i < 8; i++) chk("bc_addr", req_at(rb + i), 16'h1000 + i);
    chk("bc_nwr", we_log.size() - wb, 8);
    for (int i = 0; i < 8; i++) begin
      chk("bc_we", we_at(wb + i), 4'hF);
      chk("bc_data", dat_at(wb + i), line_of(16'h1000 + i));
    end
    chk("bc_ndone", done_cnt - db, 1);
    chk("bc_done_lat", done_cyc - wcyc_log[we_log.size() - 1], 1);
    chk("bc_busy_lo", op_busy, 0);
    chk("bc_stray", stray_rsp, 0);

    // Round-robin, sparse mask
    lat = 2;
    wb = we_log.size(); db = done_cnt;
    start_op(16'h2000, 5, 4'b1010, 1'b1);
    wait_done(db, 200);
    chk("rr_nwr", we_log.size() - wb, 5);
    for (int i = 0; i < 5; i++) begin
      chk("rr_we", we_at(wb + i), rr_exp[i]);
      chk("rr_data", dat_at(wb + i), line_of(16'h2000 + i));
    end

    // Credit limit with every channel almost full
    lat = 1;
    ch_almostfull = 4'hF;
    rb = req_log.size(); wb = we_log.size(); db = done_cnt;
    start_op(16'h3000, 20, 4'hF, 1'b0);
    repeat (40) tick();
    chk("cr_nreq_stall", req_log.size() - rb, 8);
    chk("cr_nwr_stall", we_log.size() - wb, 0);
    ch_almostfull = '0;
    wait_done(db, 400);
    chk("cr_nreq", req_log.size() - rb, 20);
    chk("cr_nwr", we_log.size() - wb, 20);
    for (int i = 0; i < 20; i++) chk("cr_data", dat_at(wb + i), line_of(16'h3000 + i));

    // Zero length and empty mask
    rb = req_log.size(); wb = we_log.size(); db = done_cnt;
    start_op(16'h4000, 0, 4'hF, 1'b0);
    wait_done(db, 20);
    chk("z_lat", done_cyc - start_cyc, 2);
    repeat (2) tick();
    chk("z_nreq", req_log.size() - rb, 0);
    db = done_cnt;
    start_op(16'h4000, 4, 4'h0, 1'b0);
    wait_done(db, 20);
    chk("m_lat", done_cyc - start_cyc, 2);
    repeat (2) tick();
    chk("m_nreq", req_log.size() - rb, 0);
    chk("m_nwr", we_log.size() - wb, 0);

    // Request back-pressure toggling every cycle
    lat = 2;
    rb = req_log.size(); wb = we_log.size(); db = done_cnt; vb = viol_cnt;
    start_op(16'h4800, 6, 4'hF, 1'b0);
    n = 0;
    while (done_cnt == db && n < 200) begin
      rd_req_almfull = ~rd_req_almfull;
      tick();
      n++;
    end
    rd_req_almfull = 1'b0;
    chk("bp_done", 64'(done_cnt != db), 1);
    chk("bp_viol", viol_cnt - vb, 0);
    chk("bp_nreq", req_log.size() - rb, 6);
    chk("bp_nwr", we_log.size() - wb, 6);

    // Stray response in IDLE, cleared by next start; single-bit round-robin mask
    tick();
    inj_valid = 1'b1;
    tick();
    inj_valid = 1'b0;
    tick();
    chk("stray_set", stray_rsp, 1);
    repeat (3) tick();
    chk("stray_hold", stray_rsp, 1);
    wb = we_log.size(); db = done_cnt;
    start_op(16'h4900, 3, 4'b0001, 1'b1);
    chk("stray_clr", stray_rsp, 0);
    wait_done(db, 100);
    chk("one_nwr", we_log.size() - wb, 3);
    for (int i = 0; i < 3; i++) chk("one_we", we_at(wb + i), 4'b0001);

    // Asynchronous reset mid-transfer, then a fresh operation
    lat = 3;
    wb = we_log.size(); db = done_cnt;
    start_op(16'h5000, 10, 4'hF, 1'b0);
    n = 0;
    while (we_log.size() - wb < 3 && n < 100) begin
      tick();
      n++;
    end
    chk("ar_three", 64'(we_log.size() - wb >= 3), 1);
    reset = 1'b1;
    #1;
    chk("ar_busy", op_busy, 0);
    chk("ar_done", op_done, 0);
    chk("ar_stray", stray_rsp, 0);
    chk("ar_req", rd_req_valid, 0);
    chk("ar_addr", rd_req_addr, 0);
    chk("ar_we", ch_we, 0);
    chk("ar_wdata", ch_wdata, 0);
    tick(); tick();
    reset = 1'b0;
    repeat (12) tick();
    chk("ar_stray_late", stray_rsp, 1);
    chk("ar_no_done", done_cnt - db, 0);
    chk("ar_drained", mq_addr.size(), 0);
    wb = we_log.size(); db = done_cnt;
    start_op(16'h6000, 2, 4'hF, 1'b0);
    chk("ar_stray_clr", stray_rsp, 0);
    wait_done(db, 100);
    chk("ar_nwr", we_log.size() - wb, 2);
    for (int i = 0; i < 2; i++) chk("ar_data", dat_at(wb + i), line_of(16'h6000 + i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
